cart_01_mmc1: RTL and testbench
===============================

Name: cart_01_mmc1

Overview:
- Mapper 01 (MMC1) banking core for the FPGA NES cart; successor to the fixed-map mapper-00 cart, with parametrised PRG/CHR bank counts.
- Decodes CPU serial writes into the MMC1 registers and translates CPU/PPU addresses into banked PRG and CHR memory addresses.
- Generates the PRG fetch request for the SDRAM controller and drives CIRAM mirroring; the memory controllers are instantiated outside this block.

Parameters:
- PRG_BANKS_LOG2, 4, log2 of the number of 16KB PRG banks (legal 1..4).
- CHR_BANKS_LOG2, 5, log2 of the number of 4KB CHR banks (legal 1..5).
- CHR_RAM, 0, 1 = CHR space is writable RAM (enables chr_we_out).

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- init_done  in  1  memory preload complete.
- rst_out  out  1  console reset hold.
- prg_nce_in  in  1  PRG-ROM select, active low ($8000-$FFFF).
- prg_a_in  in  15  CPU address bits 14:0.
- prg_r_nw_in  in  1  CPU read/write.
- prg_d_in  in  8  CPU write data.
- wram_sel_in  in  1  decoded $6000-$7FFF select, active high.
- chr_a_in  in  14  PPU address.
- chr_r_nw_in  in  1  PPU read/write.
- prg_addr_out  out  14+PRG_BANKS_LOG2  banked PRG-ROM byte address.
- prg_req_out  out  1  one-cycle fetch request.
- wram_ce_out  out  1  PRG-RAM enable.
- chr_addr_out  out  12+CHR_BANKS_LOG2  banked CHR byte address.
- chr_we_out  out  1  CHR-RAM write enable.
- ciram_nce_out  out  1  CIRAM enable, active low.
- ciram_a10_out  out  1  CIRAM A10.

Behaviour:
- Reset (async): shift=5'b10000, control=5'b01100, chr0=chr1=prg=0, wr_arm=0, prev_addr=all ones, prg_req_out=0, rst_out=1.
- rst_out: cleared on the first rising edge with init_done=1; stays 0 until the next rst.
- Write condition: wc = ~prg_nce_in & ~prg_r_nw_in. A write is accepted only on the first clk_sys edge of each wc assertion; wr_arm is the registered wc. Later cycles of the same CPU write are ignored.
- Accepted write with d[7]=1: shift<=10000 and control[3:2]<=11 on the same edge; the other registers are unchanged.
- Accepted write with d[7]=0, shift[0]=0: shift<={d[0],shift[4:1]}.
- Accepted write with d[7]=0, shift[0]=1 (fifth write): value={d[0],shift[4:1]}; it is loaded into the register chosen by a[14:13] (00 control, 01 chr0, 10 chr1, 11 prg), and shift<=10000 on the same edge.
- PRG mapping: a14=prg_a_in[14]; b=prg[3:0] truncated to PRG_BANKS_LOG2 bits; last=all ones.
  - control[3:2]=0x (32KB mode): bank={b[high:1],a14}.
  - control[3:2]=10: bank = a14 ? b : 0.
  - control[3:2]=11: bank = a14 ? last : b.
  - prg_addr_out={bank,prg_a_in[13:0]}, combinational.
- prg_req_out: a registered pulse, high for one cycle when prg_addr_out differs from prev_addr; prev_addr<=prg_addr_out every cycle. This covers bank-register changes with a stable CPU address. The first cycle after reset always requests.
- wram_ce_out = wram_sel_in & ~prg[4], combinational.
- CHR mapping: a12=chr_a_in[12]; c0/c1 = chr0/chr1 truncated to CHR_BANKS_LOG2 bits.
  - control[4]=0: bank={c0[high:1],a12}.
  - control[4]=1: bank = a12 ? c1 : c0.
  - chr_addr_out={bank,chr_a_in[11:0]}.
- chr_we_out = CHR_RAM & ~chr_r_nw_in & ~chr_a_in[13].
- ciram_nce_out=~chr_a_in[13].
- ciram_a10_out selected by control[1:0]: 00→0, 01→1, 10→chr_a_in[10] (vertical), 11→chr_a_in[11] (horizontal).
- Register updates take effect on mapping outputs in the cycle after the accepting edge.
- Reset mid-sequence discards partial shift contents. Reads never alter the shift register.

Test Plan:
- Reset, then init_done=1 at cycle 5 → rst_out falls at edge 5. prg_a_in=7FFC → prg_addr_out=0x3FFFC (mode 3, last bank 15). prg_req_out pulses once.
- Five single-cycle writes to $E000 with d[0] sequence 1,0,1,0,0 → prg=00101. prg_a_in=0000 → prg_addr_out=0x14000. prg_req_out pulses one cycle after the fifth write.
- Hold one write (d=01) asserted for 4 cycles → shift advances once only. Then write d=80 → shift=10000 and control=xx11xx.
- Write control=00010, then chr0=00011 → chr_a_in=1234 gives chr_addr_out=0x03234 (8KB mode, bank {0001,1}). ciram_a10_out follows chr_a_in[10].
- Write control=10011, chr0=4, chr1=7 → chr_a_in=0x0100 gives chr_addr_out=0x4100; chr_a_in=0x1100 gives 0x7100. chr_a_in=0x2800 gives ciram_a10_out=1 and ciram_nce_out=0.
- Three writes in, assert rst asynchronously mid-cycle → all registers return to reset values immediately. The next five writes load a full register.

Source files
------------

// File: rtl/cart_01_mmc1_if.sv
// CPU/PPU-side bus of the MMC1 mapper core: console reset hand-off, PRG and CHR
// address/control in, banked memory addresses and CIRAM controls out.
interface cart_01_mmc1_if #(
   parameter int PRG_BANKS_LOG2 = 4,
   parameter int CHR_BANKS_LOG2 = 5
);
   logic                         init_done;
   logic                         rst_out;
   logic                         prg_nce_in;
   logic [14:0]                  prg_a_in;
   logic                         prg_r_nw_in;
   logic [7:0]                   prg_d_in;
   logic                         wram_sel_in;
   logic [13:0]                  chr_a_in;
   logic                         chr_r_nw_in;
   logic [13+PRG_BANKS_LOG2:0]   prg_addr_out;
   logic                         prg_req_out;
   logic                         wram_ce_out;
   logic [11+CHR_BANKS_LOG2:0]   chr_addr_out;
   logic                         chr_we_out;
   logic                         ciram_nce_out;
   logic                         ciram_a10_out;

   modport master (
      output init_done, prg_nce_in, prg_a_in, prg_r_nw_in, prg_d_in,
             wram_sel_in, chr_a_in, chr_r_nw_in,
      input  rst_out, prg_addr_out, prg_req_out, wram_ce_out, chr_addr_out,
             chr_we_out, ciram_nce_out, ciram_a10_out
   );

   modport slave (
      input  init_done, prg_nce_in, prg_a_in, prg_r_nw_in, prg_d_in,
             wram_sel_in, chr_a_in, chr_r_nw_in,
      output rst_out, prg_addr_out, prg_req_out, wram_ce_out, chr_addr_out,
             chr_we_out, ciram_nce_out, ciram_a10_out
   );
endinterface

// File: rtl/cart_01_mmc1.sv
// MMC1 (mapper 01) banking core: serial register loader, PRG/CHR bank translation,
// PRG fetch request generation and CIRAM mirroring control.
module cart_01_mmc1 #(
   parameter int PRG_BANKS_LOG2 = 4,
   parameter int CHR_BANKS_LOG2 = 5,
   parameter int CHR_RAM        = 0
) (
   input  logic           clk_sys,
   input  logic           rst,
   cart_01_mmc1_if.slave  bus
);
   localparam int PW = PRG_BANKS_LOG2;
   localparam int CW = CHR_BANKS_LOG2;
   localparam int PA = 14 + PW;

   logic [4:0]    shift_reg;
   logic [4:0]    control;
   logic [4:0]    chr0;
   logic [4:0]    chr1;
   logic [4:0]    prg;
   logic          wr_arm;
   logic          first_cycle;
   logic          prg_req;
   logic          rst_hold;
   logic [PA-1:0] prev_addr;
   logic [PA-1:0] prg_addr;

   logic          wc;
   logic          accept;
   logic [4:0]    shift_value;
   logic          a14;
   logic          a12;
   logic [PW-1:0] prg_b;
   logic [PW-1:0] prg_bank32;
   logic [PW-1:0] prg_bank;
   logic [CW-1:0] c0;
   logic [CW-1:0] c1;
   logic [CW-1:0] chr_bank8;
   logic [CW-1:0] chr_bank;
   logic          ciram_a10;
   logic          unused_ok;

   // Only the first edge of a (possibly multi-cycle) CPU write is accepted.
   assign wc          = ~bus.prg_nce_in & ~bus.prg_r_nw_in;
   assign accept      = wc & ~wr_arm;
   assign shift_value = {bus.prg_d_in[0], shift_reg[4:1]};

   assign a14   = bus.prg_a_in[14];
   assign a12   = bus.chr_a_in[12];
   assign prg_b = prg[PW-1:0];
   assign c0    = chr0[CW-1:0];
   assign c1    = chr1[CW-1:0];

   // 32KB / 8KB modes ignore the bank LSB and use the address bit instead.
   generate
      if (PW > 1) begin : g_prg32
         assign prg_bank32 = {prg_b[PW-1:1], a14};
      end else begin : g_prg32_min
         assign prg_bank32 = a14;
      end
      if (CW > 1) begin : g_chr8
         assign chr_bank8 = {c0[CW-1:1], a12};
      end else begin : g_chr8_min
         assign chr_bank8 = a12;
      end
   endgenerate

   always_comb begin
      prg_bank = prg_bank32;
      case (control[3:2])
         2'b10:   prg_bank = a14 ? prg_b : '0;
         2'b11:   prg_bank = a14 ? '1 : prg_b;
         default: prg_bank = prg_bank32;
      endcase
   end

   always_comb begin
      chr_bank = chr_bank8;
      if (control[4]) begin
         chr_bank = a12 ? c1 : c0;
      end
   end

   always_comb begin
      ciram_a10 = 1'b0;
      case (control[1:0])
         2'b00:   ciram_a10 = 1'b0;
         2'b01:   ciram_a10 = 1'b1;
         2'b10:   ciram_a10 = bus.chr_a_in[10];
         default: ciram_a10 = bus.chr_a_in[11];
      endcase
   end

   assign prg_addr = {prg_bank, bus.prg_a_in[13:0]};

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         shift_reg   <= 5'b10000;
         control     <= 5'b01100;
         chr0        <= '0;
         chr1        <= '0;
         prg         <= '0;
         wr_arm      <= 1'b0;
         first_cycle <= 1'b1;
         prev_addr   <= '1;
         prg_req     <= 1'b0;
         rst_hold    <= 1'b1;
      end else begin
         wr_arm      <= wc;
         first_cycle <= 1'b0;
         prev_addr   <= prg_addr;
         // Any change of the banked address, including a bank switch under a
         // stable CPU address, triggers a fresh fetch.
         prg_req     <= first_cycle | (prg_addr != prev_addr);
         if (bus.init_done) begin
            rst_hold <= 1'b0;
         end
         if (accept) begin
            if (bus.prg_d_in[7]) begin
               shift_reg    <= 5'b10000;
               control[3:2] <= 2'b11;
            end else if (!shift_reg[0]) begin
               shift_reg <= shift_value;
            end else begin
               shift_reg <= 5'b10000;
               case (bus.prg_a_in[14:13])
                  2'b00:   control <= shift_value;
                  2'b01:   chr0    <= shift_value;
                  2'b10:   chr1    <= shift_value;
                  default: prg     <= shift_value;
               endcase
            end
         end
      end
   end

   assign bus.rst_out       = rst_hold;
   assign bus.prg_addr_out  = prg_addr;
   assign bus.prg_req_out   = prg_req;
   assign bus.wram_ce_out   = bus.wram_sel_in & ~prg[4];
   assign bus.chr_addr_out  = {chr_bank, bus.chr_a_in[11:0]};
   assign bus.chr_we_out    = (CHR_RAM != 0) & ~bus.chr_r_nw_in & ~bus.chr_a_in[13];
   assign bus.ciram_nce_out = ~bus.chr_a_in[13];
   assign bus.ciram_a10_out = ciram_a10;

   assign unused_ok = ^{bus.prg_d_in[6:1], prg, chr0, chr1};
endmodule

// File: tb/tb_cart_01_mmc1.sv
// Directed bench for the MMC1 core: reset hand-off, serial loads, PRG/CHR banking,
// mirroring, write-edge filtering and asynchronous reset mid-sequence.
module tb_cart_01_mmc1;
   logic clk_sys;
   logic rst;
   int   n_assert;
   int   n_fail;

   cart_01_mmc1_if #(.PRG_BANKS_LOG2(4), .CHR_BANKS_LOG2(5)) bus ();

   cart_01_mmc1 #(
      .PRG_BANKS_LOG2 (4),
      .CHR_BANKS_LOG2 (5),
      .CHR_RAM        (0)
   ) dut (
      .clk_sys (clk_sys),
      .rst     (rst),
      .bus     (bus)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, required end before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic cpu_write(input logic [14:0] a, input logic [7:0] d, input int hold);
      bus.prg_a_in    = a;
      bus.prg_d_in    = d;
      bus.prg_nce_in  = 1'b0;
      bus.prg_r_nw_in = 1'b0;
      repeat (hold) tick();
      bus.prg_nce_in  = 1'b1;
      bus.prg_r_nw_in = 1'b1;
      tick();
      $display("write a=%04h d=%02h hold=%0d", a, d, hold);
   endtask

   task automatic mmc_load(input logic [14:0] a, input logic [4:0] v);
      for (int i = 0; i < 5; i++) begin
         cpu_write(a, {7'b0, v[i]}, 1);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst             = 1'b1;
      bus.init_done   = 1'b0;
      bus.prg_nce_in  = 1'b1;
      bus.prg_a_in    = 15'h7FFC;
      bus.prg_r_nw_in = 1'b1;
      bus.prg_d_in    = 8'h00;
      bus.wram_sel_in = 1'b0;
      bus.chr_a_in    = 14'h0000;
      bus.chr_r_nw_in = 1'b1;

      // Reset state
      #3;
      chk("rst_out_reset", bus.rst_out, 1);
      chk("prg_addr_reset", bus.prg_addr_out, 32'h3FFFC);
      chk("prg_req_reset", bus.prg_req_out, 0);
      chk("ciram_a10_reset", bus.ciram_a10_out, 0);
      chk("wram_ce_nosel", bus.wram_ce_out, 0);
      #9 rst = 1'b0;
      tick();
      chk("prg_req_first", bus.prg_req_out, 1);
      chk("rst_out_hold", bus.rst_out, 1);
      tick();
      chk("prg_req_once", bus.prg_req_out, 0);
      tick();
      tick();
      chk("rst_out_hold2", bus.rst_out, 1);
      bus.init_done = 1'b1;
      tick();
      chk("rst_out_release", bus.rst_out, 0);
      bus.init_done = 1'b0;
      tick();
      chk("rst_out_sticky", bus.rst_out, 0);
      bus.init_done = 1'b1;

      // PRG register load, mode 3 (fixed last bank high)
      mmc_load(15'h6000, 5'b00101);
      bus.prg_a_in    = 15'h0000;
      bus.wram_sel_in = 1'b1;
      #1;
      chk("prg_addr_bank5", bus.prg_addr_out, 32'h14000);
      chk("wram_ce_on", bus.wram_ce_out, 1);

      // 32KB PRG mode, 4KB CHR; held write must shift once only
      mmc_load(15'h0000, 5'b10011);
      cpu_write(15'h4000, 8'h01, 4);
      for (int i = 0; i < 4; i++) cpu_write(15'h4000, 8'h00, 1);
      bus.chr_a_in = 14'h1000;
      #1;
      chk("held_write_chr1", bus.chr_addr_out, 32'h01000);
      bus.prg_a_in = 15'h0000;
      #1;
      chk("prg32_low", bus.prg_addr_out, 32'h10000);
      bus.prg_a_in = 15'h4000;
      #1;
      chk("prg32_high", bus.prg_addr_out, 32'h14000);

      // Partial sequence then reset write
      cpu_write(15'h4000, 8'h01, 1);
      cpu_write(15'h4000, 8'h01, 1);
      cpu_write(15'h0000, 8'h80, 1);
      bus.prg_a_in = 15'h0000;
      bus.chr_a_in = 14'h0800;
      #1;
      chk("d80_prg_mode3", bus.prg_addr_out, 32'h14000);
      chk("d80_ctrl_kept_mirror", bus.ciram_a10_out, 1);
      mmc_load(15'h4000, 5'b00110);
      bus.chr_a_in = 14'h1000;
      #1;
      chk("d80_shift_cleared", bus.chr_addr_out, 32'h06000);

      // Mode 10: bank switch under stable CPU address requests a fetch
      mmc_load(15'h0000, 5'b01010);
      cpu_write(15'h6000, 8'h01, 1);
      cpu_write(15'h6000, 8'h01, 1);
      cpu_write(15'h6000, 8'h00, 1);
      cpu_write(15'h6000, 8'h00, 1);
      chk("mode2_before", bus.prg_addr_out, 32'h16000);
      chk("req_idle", bus.prg_req_out, 0);
      cpu_write(15'h6000, 8'h01, 1);
      chk("req_bank_switch", bus.prg_req_out, 1);
      chk("mode2_after", bus.prg_addr_out, 32'h0E000);
      chk("wram_ce_off", bus.wram_ce_out, 0);
      tick();
      chk("req_single", bus.prg_req_out, 0);
      bus.prg_a_in = 15'h2000;
      #1;
      chk("mode2_low_zero", bus.prg_addr_out, 32'h02000);

      // 8KB CHR mode, vertical mirroring
      mmc_load(15'h0000, 5'b00010);
      mmc_load(15'h2000, 5'b00011);
      bus.chr_a_in = 14'h1234;
      #1;
      chk("chr8_addr", bus.chr_addr_out, 32'h03234);
      chk("vert_a10_lo", bus.ciram_a10_out, 0);
      bus.chr_a_in = 14'h0400;
      #1;
      chk("chr8_addr_lo", bus.chr_addr_out, 32'h02400);
      chk("vert_a10_hi", bus.ciram_a10_out, 1);

      // 4KB CHR mode, horizontal mirroring
      mmc_load(15'h0000, 5'b10011);
      mmc_load(15'h2000, 5'd4);
      mmc_load(15'h4000, 5'd7);
      bus.chr_a_in = 14'h0100;
      #1;
      chk("chr4_c0", bus.chr_addr_out, 32'h04100);
      bus.chr_a_in = 14'h1100;
      #1;
      chk("chr4_c1", bus.chr_addr_out, 32'h07100);
      bus.chr_a_in = 14'h2800;
      #1;
      chk("horiz_a10", bus.ciram_a10_out, 1);
      chk("ciram_nce_on", bus.ciram_nce_out, 0);
      bus.chr_a_in = 14'h0800;
      #1;
      chk("ciram_nce_off", bus.ciram_nce_out, 1);
      bus.chr_r_nw_in = 1'b0;
      bus.chr_a_in    = 14'h0000;
      #1;
      chk("chr_we_rom", bus.chr_we_out, 0);
      bus.chr_r_nw_in = 1'b1;

      // Asynchronous reset in the middle of a serial load
      bus.chr_a_in = 14'h2800;
      cpu_write(15'h6000, 8'h01, 1);
      cpu_write(15'h6000, 8'h01, 1);
      cpu_write(15'h6000, 8'h01, 1);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_out", bus.rst_out, 1);
      chk("async_ctrl_mirror", bus.ciram_a10_out, 0);
      chk("async_req_clear", bus.prg_req_out, 0);
      bus.prg_a_in = 15'h0000;
      #1;
      chk("async_prg_clear", bus.prg_addr_out, 32'h00000);
      rst = 1'b0;
      tick();
      chk("rst_out_rerelease", bus.rst_out, 0);
      mmc_load(15'h6000, 5'b01001);
      bus.prg_a_in = 15'h0000;
      #1;
      chk("post_rst_full_load", bus.prg_addr_out, 32'h24000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
